// File: rtl/partition_alloc_arbiter.sv
// Partition module table controller: round-robin arbitration of PNEW requests,
// sequential dedup scan, allocation with ID assignment and mu-discovery charging.
module partition_alloc_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_MODULES = 64,
    parameter int ID_W        = 32,
    parameter int MU_W        = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*6-1:0] req_region,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_req,
    output logic [ID_W-1:0]      rsp_module_id,
    output logic [5:0]           rsp_index,
    output logic                 rsp_new,
    output logic                 rsp_full,
    output logic [6:0]           num_modules,
    output logic [5:0]           current_idx,
    output logic [MU_W-1:0]      mu_discovery,
    input  logic [5:0]           rd_idx,
    output logic [63:0]          rd_mask,
    output logic [ID_W-1:0]      rd_id
);
    localparam int         IW    = (MAX_MODULES > 1) ? $clog2(MAX_MODULES) : 1;
    localparam logic [6:0] MAX_N = 7'(MAX_MODULES);

    typedef enum logic [1:0] {IDLE, SCAN, ALLOC, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        req_idx_q, req_idx_d;
    logic [5:0]        region_q, region_d;
    logic [5:0]        scan_idx_q, scan_idx_d;
    logic [ID_W-1:0]   next_id_q, next_id_d;
    logic [6:0]        num_modules_q, num_modules_d;
    logic [5:0]        current_idx_q, current_idx_d;
    logic [MU_W-1:0]   mu_q, mu_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_req_q, rsp_req_d;
    logic [ID_W-1:0]   rsp_module_id_q, rsp_module_id_d;
    logic [5:0]        rsp_index_q, rsp_index_d;
    logic              rsp_new_q, rsp_new_d;
    logic              rsp_full_q, rsp_full_d;
    logic [63:0]       tbl_mask_q [MAX_MODULES];
    logic [63:0]       tbl_mask_d [MAX_MODULES];
    logic [ID_W-1:0]   tbl_id_q   [MAX_MODULES];
    logic [ID_W-1:0]   tbl_id_d   [MAX_MODULES];

    logic              gnt_found;
    logic [2:0]        gnt_idx;
    logic [5:0]        gnt_region;
    logic [63:0]       region_mask;
    logic              rd_hit;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int cand;
        cand       = 0;
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_region = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found  = 1'b1;
                gnt_idx    = 3'(cand);
                gnt_region = req_region[cand*6 +: 6];
            end
        end
    end

    assign req_ready = (rst_n && state_q == IDLE && gnt_found) ?
                       ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

    assign region_mask = 64'h1 << region_q;

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        req_idx_d       = req_idx_q;
        region_d        = region_q;
        scan_idx_d      = scan_idx_q;
        next_id_d       = next_id_q;
        num_modules_d   = num_modules_q;
        current_idx_d   = current_idx_q;
        mu_d            = mu_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_req_d       = rsp_req_q;
        rsp_module_id_d = rsp_module_id_q;
        rsp_index_d     = rsp_index_q;
        rsp_new_d       = rsp_new_q;
        rsp_full_d      = rsp_full_q;
        tbl_mask_d      = tbl_mask_q;
        tbl_id_d        = tbl_id_q;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d    = SCAN;
                    req_idx_d  = gnt_idx;
                    region_d   = gnt_region;
                    scan_idx_d = '0;
                    rr_ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;
                end
            end
            SCAN: begin
                if (tbl_mask_q[scan_idx_q[IW-1:0]] == region_mask) begin
                    state_d         = RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_req_d       = req_idx_q;
                    rsp_module_id_d = tbl_id_q[scan_idx_q[IW-1:0]];
                    rsp_index_d     = scan_idx_q;
                    rsp_new_d       = 1'b0;
                    rsp_full_d      = 1'b0;
                    current_idx_d   = scan_idx_q;
                end else if ({1'b0, scan_idx_q} == num_modules_q - 7'd1) begin
                    if (num_modules_q == MAX_N) begin
                        // Table full: answer without touching table, current_idx or mu.
                        state_d         = RESP;
                        rsp_valid_d     = 1'b1;
                        rsp_req_d       = req_idx_q;
                        rsp_module_id_d = '0;
                        rsp_index_d     = '0;
                        rsp_new_d       = 1'b0;
                        rsp_full_d      = 1'b1;
                    end else begin
                        state_d = ALLOC;
                    end
                end else begin
                    scan_idx_d = scan_idx_q + 6'd1;
                end
            end
            ALLOC: begin
                tbl_mask_d[num_modules_q[IW-1:0]] = region_mask;
                tbl_id_d[num_modules_q[IW-1:0]]   = next_id_q;
                next_id_d       = next_id_q + 1'b1;
                num_modules_d   = num_modules_q + 7'd1;
                current_idx_d   = num_modules_q[5:0];
                mu_d            = mu_q + MU_W'($countones(region_mask));
                state_d         = RESP;
                rsp_valid_d     = 1'b1;
                rsp_req_d       = req_idx_q;
                rsp_module_id_d = next_id_q;
                rsp_index_d     = num_modules_q[5:0];
                rsp_new_d       = 1'b1;
                rsp_full_d      = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            req_idx_q       <= '0;
            region_q        <= '0;
            scan_idx_q      <= '0;
            next_id_q       <= ID_W'(1);
            num_modules_q   <= 7'd1;
            current_idx_q   <= '0;
            mu_q            <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_req_q       <= '0;
            rsp_module_id_q <= '0;
            rsp_index_q     <= '0;
            rsp_new_q       <= 1'b0;
            rsp_full_q      <= 1'b0;
            for (int i = 0; i < MAX_MODULES; i++) begin
                tbl_mask_q[i] <= (i == 0) ? 64'h1 : 64'h0;
                tbl_id_q[i]   <= '0;
            end
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            req_idx_q       <= req_idx_d;
            region_q        <= region_d;
            scan_idx_q      <= scan_idx_d;
            next_id_q       <= next_id_d;
            num_modules_q   <= num_modules_d;
            current_idx_q   <= current_idx_d;
            mu_q            <= mu_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_req_q       <= rsp_req_d;
            rsp_module_id_q <= rsp_module_id_d;
            rsp_index_q     <= rsp_index_d;
            rsp_new_q       <= rsp_new_d;
            rsp_full_q      <= rsp_full_d;
            tbl_mask_q      <= tbl_mask_d;
            tbl_id_q        <= tbl_id_d;
        end
    end

    assign rd_hit  = ({1'b0, rd_idx} < num_modules_q);
    assign rd_mask = rd_hit ? tbl_mask_q[rd_idx[IW-1:0]] : '0;
    assign rd_id   = rd_hit ? tbl_id_q[rd_idx[IW-1:0]]   : '0;

    assign rsp_valid     = rsp_valid_q;
    assign rsp_req       = rsp_req_q;
    assign rsp_module_id = rsp_module_id_q;
    assign rsp_index     = rsp_index_q;
    assign rsp_new       = rsp_new_q;
    assign rsp_full      = rsp_full_q;
    assign num_modules   = num_modules_q;
    assign current_idx   = current_idx_q;
    assign mu_discovery  = mu_q;

endmodule

// File: tb/tb_partition_alloc_arbiter.sv
// Directed bench for partition_alloc_arbiter: default-size instance plus a
// four-entry instance for the table-full path.
module tb_partition_alloc_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        use_small;
    logic [3:0]  req_valid, s_req_valid;
    logic [23:0] req_region, s_req_region;
    logic        rsp_ready, s_rsp_ready;
    logic [5:0]  rd_idx, s_rd_idx;

    logic [3:0]  m_req_ready, s_req_ready;
    logic        m_rsp_valid, s_rsp_valid;
    logic [2:0]  m_rsp_req, s_rsp_req;
    logic [31:0] m_rsp_module_id, s_rsp_module_id;
    logic [5:0]  m_rsp_index, s_rsp_index;
    logic        m_rsp_new, s_rsp_new;
    logic        m_rsp_full, s_rsp_full;
    logic [6:0]  m_num_modules, s_num_modules;
    logic [5:0]  m_current_idx, s_current_idx;
    logic [63:0] m_mu, s_mu;
    logic [63:0] rd_mask, s_rd_mask;
    logic [31:0] rd_id, s_rd_id;

    wire [3:0]  req_ready     = use_small ? s_req_ready     : m_req_ready;
    wire        rsp_valid     = use_small ? s_rsp_valid     : m_rsp_valid;
    wire [2:0]  rsp_req       = use_small ? s_rsp_req       : m_rsp_req;
    wire [31:0] rsp_module_id = use_small ? s_rsp_module_id : m_rsp_module_id;
    wire [5:0]  rsp_index     = use_small ? s_rsp_index     : m_rsp_index;
    wire        rsp_new       = use_small ? s_rsp_new       : m_rsp_new;
    wire        rsp_full      = use_small ? s_rsp_full      : m_rsp_full;
    wire [6:0]  num_modules   = use_small ? s_num_modules   : m_num_modules;
    wire [5:0]  current_idx   = use_small ? s_current_idx   : m_current_idx;
    wire [63:0] mu_discovery  = use_small ? s_mu            : m_mu;

    partition_alloc_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_region(req_region), .req_ready(m_req_ready),
        .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_req(m_rsp_req),
        .rsp_module_id(m_rsp_module_id), .rsp_index(m_rsp_index),
        .rsp_new(m_rsp_new), .rsp_full(m_rsp_full),
        .num_modules(m_num_modules), .current_idx(m_current_idx),
        .mu_discovery(m_mu), .rd_idx(rd_idx), .rd_mask(rd_mask), .rd_id(rd_id)
    );

    partition_alloc_arbiter #(.MAX_MODULES(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_region(s_req_region), .req_ready(s_req_ready),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_req(s_rsp_req),
        .rsp_module_id(s_rsp_module_id), .rsp_index(s_rsp_index),
        .rsp_new(s_rsp_new), .rsp_full(s_rsp_full),
        .num_modules(s_num_modules), .current_idx(s_current_idx),
        .mu_discovery(s_mu), .rd_idx(s_rd_idx), .rd_mask(s_rd_mask), .rd_id(s_rd_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = '0;
        s_req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    // Issue one request, return grant wait and response latency measured from the grant cycle.
    task automatic do_req(input int r, input logic [5:0] region, output int gwait, output int lat);
        if (use_small) begin
            s_req_valid[r]          = 1'b1;
            s_req_region[r*6 +: 6]  = region;
        end else begin
            req_valid[r]            = 1'b1;
            req_region[r*6 +: 6]    = region;
        end
        #1;
        gwait = 0;
        while (req_ready[r] !== 1'b1 && gwait < 200) begin
            step();
            gwait++;
        end
        check("grant_onehot", 64'(req_ready), 64'(1) << r);
        step();
        if (use_small) s_req_valid[r] = 1'b0;
        else           req_valid[r]   = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int g, l, n, bad, cnt;
        use_small    = 1'b1;
        rst_n        = 1'b0;
        req_valid    = 4'hF;
        req_region   = '0;
        s_req_valid  = 4'hF;
        s_req_region = '0;
        rsp_ready    = 1'b1;
        s_rsp_ready  = 1'b1;
        rd_idx       = '0;
        s_rd_idx     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        req_valid   = '0;
        s_req_valid = '0;
        rst_n       = 1'b1;
        step();

        // Four-entry table: fill, then a new region must report full.
        do_req(0, 6'd1, g, l);
        check("s_alloc1_lat", 64'(l), 64'd3);
        step();
        do_req(0, 6'd2, g, l);
        check("s_alloc2_id", 64'(rsp_module_id), 64'd2);
        step();
        do_req(0, 6'd3, g, l);
        check("s_alloc3_lat", 64'(l), 64'd5);
        step();
        do_req(0, 6'd4, g, l);
        check("s_full_lat", 64'(l), 64'd5);
        check("s_full_flags", {rsp_full, rsp_new, rsp_index, rsp_module_id}, {1'b1, 1'b0, 6'd0, 32'd0});
        step();
        check("s_full_num", 64'(num_modules), 64'd4);
        check("s_full_mu", mu_discovery, 64'd3);
        check("s_full_cur", 64'(current_idx), 64'd3);
        do_req(0, 6'd2, g, l);
        check("s_hit_after_full", {rsp_full, rsp_new, rsp_index, rsp_module_id}, {1'b0, 1'b0, 6'd2, 32'd2});
        check("s_hit_lat", 64'(l), 64'd4);
        step();
        use_small = 1'b0;

        // Main instance: reset state.
        do_reset();
        check("rst_num", 64'(num_modules), 64'd1);
        check("rst_mu", mu_discovery, 64'd0);
        check("rst_cur", 64'(current_idx), 64'd0);
        rd_idx = 6'd0;
        #1;
        check("rst_rd0", {rd_mask, rd_id}, {64'h1, 32'd0});
        rd_idx = 6'd1;
        #1;
        check("rst_rd1", {rd_mask, rd_id}, {64'h0, 32'd0});

        do_req(0, 6'd3, g, l);
        check("a3_gwait", 64'(g), 64'd0);
        check("a3_lat", 64'(l), 64'd3);
        check("a3_rsp", {rsp_req, rsp_new, rsp_full, rsp_index, rsp_module_id}, {3'd0, 1'b1, 1'b0, 6'd1, 32'd1});
        step();
        check("a3_num", 64'(num_modules), 64'd2);
        check("a3_mu", mu_discovery, 64'd1);
        check("a3_cur", 64'(current_idx), 64'd1);

        do_req(2, 6'd3, g, l);
        check("h3_lat", 64'(l), 64'd3);
        check("h3_rsp", {rsp_req, rsp_new, rsp_full, rsp_index, rsp_module_id}, {3'd2, 1'b0, 1'b0, 6'd1, 32'd1});
        step();
        check("h3_mu", mu_discovery, 64'd1);

        do_req(2, 6'd0, g, l);
        check("h0_lat", 64'(l), 64'd2);
        check("h0_rsp", {rsp_new, rsp_index, rsp_module_id}, {1'b0, 6'd0, 32'd0});
        step();
        check("h0_cur", 64'(current_idx), 64'd0);

        // Round-robin with all four requesters asserted together.
        do_reset();
        req_region = {6'd8, 6'd7, 6'd6, 6'd5};
        req_valid  = 4'hF;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready === 4'b0 && n < 200) begin
                step();
                n++;
            end
            check("rr_grant", 64'(req_ready), 64'(1) << k);
            step();
            req_valid[k] = 1'b0;
            l = 1;
            while (rsp_valid !== 1'b1 && l < 300) begin
                step();
                l++;
            end
            check("rr_lat", 64'(l), 64'(k + 3));
            check("rr_rsp", {rsp_req, rsp_new, rsp_module_id}, {3'(k), 1'b1, 32'(k + 1)});
            step();
        end
        check("rr_num", 64'(num_modules), 64'd5);
        check("rr_mu", mu_discovery, 64'd4);
        do_req(1, 6'd9, g, l);
        check("r1_gwait", 64'(g), 64'd0);
        check("r1_rsp", {rsp_req, rsp_new, rsp_index, rsp_module_id}, {3'd1, 1'b1, 6'd5, 32'd5});
        check("r1_lat", 64'(l), 64'd7);
        step();

        // Backpressure on the response channel.
        rsp_ready = 1'b0;
        do_req(0, 6'd6, g, l);
        check("bp_lat", 64'(l), 64'd4);
        req_valid[3]       = 1'b1;
        req_region[18 +: 6] = 6'd10;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {rsp_valid, rsp_new, rsp_full, rsp_req, rsp_index, rsp_module_id},
                  {1'b1, 1'b0, 1'b0, 3'd0, 6'd2, 32'd2});
            check("bp_no_ready", 64'(req_ready), 64'h0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp_regrant", 64'(req_ready), 64'h8);
        step();
        req_valid[3] = 1'b0;
        l = 1;
        while (rsp_valid !== 1'b1 && l < 300) begin
            step();
            l++;
        end
        check("bp_next_lat", 64'(l), 64'd8);
        check("bp_next_rsp", {rsp_req, rsp_new, rsp_index, rsp_module_id}, {3'd3, 1'b1, 6'd6, 32'd6});
        step();
        check("bp_mu", mu_discovery, 64'd6);

        // Asynchronous reset in the middle of a scan.
        req_valid[0]     = 1'b1;
        req_region[5:0]  = 6'd20;
        #1;
        check("ar_grant", 64'(req_ready), 64'h1);
        step();
        req_valid[0] = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", {rsp_valid, num_modules, current_idx, mu_discovery}, {1'b0, 7'd1, 6'd0, 64'd0});
        rd_idx = 6'd6;
        #1;
        check("ar_rd6", {rd_mask, rd_id}, {64'h0, 32'd0});
        rd_idx = 6'd0;
        #1;
        check("ar_rd0", rd_mask, 64'h1);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rsp_valid === 1'b1) cnt++;
        end
        check("ar_no_rsp", 64'(cnt), 64'd0);
        check("ar_num", 64'(num_modules), 64'd1);

        // Fill regions 1..63.
        bad = 0;
        for (int r = 1; r < 64; r++) begin
            do_req(0, 6'(r), g, l);
            if (rsp_module_id !== 32'(r) || rsp_index !== 6'(r) || rsp_new !== 1'b1 || l != r + 2) bad++;
            step();
        end
        check("fill_bad", 64'(bad), 64'd0);
        check("fill_num", 64'(num_modules), 64'd64);
        check("fill_mu", mu_discovery, 64'd63);
        check("fill_cur", 64'(current_idx), 64'd63);
        rd_idx = 6'd63;
        #1;
        check("fill_rd63", {rd_mask, rd_id}, {64'h8000_0000_0000_0000, 32'd63});
        do_req(0, 6'd1, g, l);
        check("fill_hit1", {rsp_new, rsp_full, rsp_index, rsp_module_id}, {1'b0, 1'b0, 6'd1, 32'd1});
        check("fill_hit1_lat", 64'(l), 64'd3);
        step();
        check("fill_mu_after", mu_discovery, 64'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
